// File: rtl/alu_writeback.sv
// ALU result writeback stage: single-byte writes, paired wide-product writes,
// architectural flags register and a retired-operation counter.
module alu_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  alu_y,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic [2:0]  rd,
  input  logic        setf,
  input  logic        wide_lo,
  input  logic        flush,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_n,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {StIdle, StWaitHi, StPairLo} state_e;

  state_e     state_q;
  logic [7:0] lo_q, hi_q;
  logic [2:0] base_q;
  logic       setf_q;
  logic       accept;

  // PAIR_LO is the only state that refuses beats; flush blocks acceptance everywhere.
  assign in_ready = !reset && !flush && (state_q != StPairLo);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wr_en   <= 1'b0;
      wr_addr <= 3'd0;
      wr_data <= 8'h00;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      retired <= 16'h0000;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      base_q  <= 3'd0;
      setf_q  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (wide_lo) begin
              lo_q    <= alu_y;
              base_q  <= rd;
              setf_q  <= setf;
              state_q <= StWaitHi;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= rd;
              wr_data <= alu_y;
              retired <= retired + 16'd1;
              if (setf) begin
                flag_c <= alu_c;
                flag_v <= alu_v;
                flag_n <= alu_n;
                flag_z <= (alu_y == 8'h00);
              end
            end
          end
        end
        StWaitHi: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (accept) begin
            // Low write is registered now so it appears during PAIR_LO.
            hi_q    <= alu_y;
            wr_en   <= 1'b1;
            wr_addr <= base_q;
            wr_data <= lo_q;
            state_q <= StPairLo;
          end
        end
        StPairLo: begin
          wr_en   <= 1'b1;
          wr_addr <= base_q + 3'd1;
          wr_data <= hi_q;
          retired <= retired + 16'd1;
          if (setf_q) begin
            flag_c <= (hi_q != 8'h00);
            flag_v <= 1'b0;
            flag_n <= hi_q[7];
            flag_z <= (lo_q == 8'h00) && (hi_q == 8'h00);
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  alu_y;
  logic        alu_c, alu_v, alu_n;
  logic [2:0]  rd;
  logic        setf, wide_lo, flush;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        flag_c, flag_v, flag_z, flag_n;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  alu_writeback dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_y    (alu_y),
    .alu_c    (alu_c),
    .alu_v    (alu_v),
    .alu_n    (alu_n),
    .rd       (rd),
    .setf     (setf),
    .wide_lo  (wide_lo),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] r, input logic [7:0] y, input logic c, input logic v,
                      input logic n, input logic sf, input logic wl);
    in_valid = 1'b1;
    rd = r; alu_y = y; alu_c = c; alu_v = v; alu_n = n; setf = sf; wide_lo = wl;
  endtask

  task automatic write_chk(input string tag, input logic [2:0] a, input logic [7:0] d);
    chk({tag, ".wr_en"}, {15'd0, wr_en}, 16'd1);
    chk({tag, ".wr_addr"}, {13'd0, wr_addr}, {13'd0, a});
    chk({tag, ".wr_data"}, {8'd0, wr_data}, {8'd0, d});
  endtask

  task automatic flags_chk(input string tag, input logic [3:0] cvzn);
    chk(tag, {12'd0, flag_c, flag_v, flag_z, flag_n}, {12'd0, cvzn});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    rd = 3'd0; alu_y = 8'h00; alu_c = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
    setf = 1'b0; wide_lo = 1'b0;
    step();
    chk("rst.in_ready", {15'd0, in_ready}, 16'd0);
    chk("rst.wr_en", {15'd0, wr_en}, 16'd0);
    flags_chk("rst.flags", 4'b0000);
    chk("rst.retired", retired, 16'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", {15'd0, in_ready}, 16'd1);

    // Normal beat with flag update
    beat(3'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    write_chk("norm", 3'd3, 8'h00);
    flags_chk("norm.flags", 4'b1010);
    chk("norm.retired", retired, 16'd1);
    step();
    chk("norm.idle_wr_en", {15'd0, wr_en}, 16'd0);

    // Wide pair; hi beat's rd/setf/wide_lo are ignored
    beat(3'd7, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("wide.lo_no_write", {15'd0, wr_en}, 16'd0);
    chk("wide.wait_ready", {15'd0, in_ready}, 16'd1);
    beat(3'd2, 8'h92, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    write_chk("wide.lo", 3'd7, 8'h34);
    chk("wide.pairlo_ready", {15'd0, in_ready}, 16'd0);
    flags_chk("wide.flags_held", 4'b1010);
    step();
    write_chk("wide.hi", 3'd0, 8'h92);
    flags_chk("wide.flags", 4'b1001);
    chk("wide.retired", retired, 16'd2);
    chk("wide.idle_ready", {15'd0, in_ready}, 16'd1);

    // Back-to-back normal beats without flag update
    for (int i = 0; i < 4; i++) begin
      beat(3'(i + 1), 8'(8'h10 + i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      write_chk($sformatf("b2b%0d", i), 3'(i + 1), 8'(8'h10 + i));
    end
    in_valid = 1'b0;
    flags_chk("b2b.flags", 4'b1001);
    chk("b2b.retired", retired, 16'd6);
    step();
    chk("b2b.idle_wr_en", {15'd0, wr_en}, 16'd0);

    // Flush in WAIT_HI discards the low half
    beat(3'd1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush.ready", {15'd0, in_ready}, 16'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush.wr_en", {15'd0, wr_en}, 16'd0);
    chk("flush.idle_ready", {15'd0, in_ready}, 16'd1);
    flags_chk("flush.flags", 4'b1001);
    beat(3'd5, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    write_chk("after_flush", 3'd5, 8'h80);
    flags_chk("after_flush.flags", 4'b0101);
    chk("after_flush.retired", retired, 16'd7);

    // Flush in IDLE blocks acceptance only
    beat(3'd2, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("idle_flush.ready", {15'd0, in_ready}, 16'd0);
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush.wr_en", {15'd0, wr_en}, 16'd0);
    chk("idle_flush.retired", retired, 16'd7);
    flags_chk("idle_flush.flags", 4'b0101);

    // Flush during PAIR_LO does not abort the pair
    beat(3'd6, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    beat(3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    write_chk("pf.lo", 3'd6, 8'h00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    write_chk("pf.hi", 3'd7, 8'h00);
    flags_chk("pf.flags", 4'b0010);
    chk("pf.retired", retired, 16'd8);

    // Asynchronous reset in PAIR_LO cancels the hi write
    beat(3'd2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    beat(3'd0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    write_chk("rp.lo", 3'd2, 8'h11);
    #2;
    reset = 1'b1;
    #1;
    chk("rp.wr_en_async", {15'd0, wr_en}, 16'd0);
    chk("rp.ready", {15'd0, in_ready}, 16'd0);
    flags_chk("rp.flags", 4'b0000);
    chk("rp.retired", retired, 16'd0);
    step();
    chk("rp.no_hi", {15'd0, wr_en}, 16'd0);
    reset = 1'b0;
    #1;
    chk("rp.release_ready", {15'd0, in_ready}, 16'd1);
    step();
    chk("rp.still_no_hi", {15'd0, wr_en}, 16'd0);

    // Counter wrap after 65536 retired beats
    beat(3'd4, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65535) step();
    chk("wrap.ffff", retired, 16'hFFFF);
    step();
    in_valid = 1'b0;
    chk("wrap.zero", retired, 16'h0000);
    step();
    step();
    chk("idle.retired_held", retired, 16'h0000);
    chk("idle.wr_en", {15'd0, wr_en}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  ALU result beat present.
REQ-005 in_ready  output  1  block accepts the beat this cycle; a beat is accepted when in_valid=1 and in_ready=1 at a rising edge.
REQ-006 alu_y  input  8  ALU result byte.
REQ-007 alu_c, alu_v, alu_n  input  1 each  ALU carry, overflow and negative.
REQ-008 rd  input  3  destination register index.
REQ-009 setf  input  1  the beat updates the flags register.
REQ-010 wide_lo  input  1  the beat is the low half of a 16-bit product; the next accepted beat is the high half.
REQ-011 flush  input  1  synchronous abort of any pending wide pair.
REQ-012 wr_en  output  1  register-file write strobe.
REQ-013 wr_addr  output  3  register-file write index.
REQ-014 wr_data  output  8  register-file write data.
REQ-015 flag_c, flag_v, flag_z, flag_n  output  1 each  architectural flags register.
REQ-016 retired  output  16  count of completed writeback operations.

Function
REQ-017 States SHALL be IDLE, WAIT_HI and PAIR_LO; all outputs SHALL be registered.
REQ-018 in_ready SHALL be 1 in IDLE and WAIT_HI, 0 in PAIR_LO, and 0 in any cycle where flush=1.
REQ-019 An IDLE accept with wide_lo=0 SHALL drive wr_en=1, wr_addr=rd and wr_data=alu_y in the next cycle; the state SHALL stay IDLE, giving one beat per cycle throughput.
REQ-020 For a normal beat with setf=1, the flags SHALL load C=alu_c, V=alu_v, N=alu_n and Z=(alu_y==8'h00), visible in the same cycle as wr_en.
REQ-021 An IDLE accept with wide_lo=1 SHALL capture alu_y as lo, capture rd as base and setf, perform no write, and go to WAIT_HI.
REQ-022 A WAIT_HI accept SHALL capture alu_y as hi and go to PAIR_LO; rd, setf and wide_lo on that beat SHALL be ignored.
REQ-023 PAIR_LO SHALL drive wr_en=1, wr_addr=base and wr_data=lo.
REQ-024 The next cycle SHALL drive wr_en=1, wr_addr=(base+1) mod 8 and wr_data=hi, and the state SHALL return to IDLE, where in_ready=1, so a new beat may be accepted in that cycle.
REQ-025 If the captured setf=1, wide-pair flags SHALL update with the hi write: C=(hi!=0), V=0, N=hi[7], Z=(lo==0 && hi==0).
REQ-026 retired SHALL increment by 1 per normal write and by 1 per wide pair (on the hi write), wrapping from 16'hFFFF to 16'h0000.
REQ-027 flush=1 in WAIT_HI SHALL discard lo, perform no write, leave flags unchanged and return to IDLE.
REQ-028 flush=1 in IDLE SHALL have no effect other than in_ready=0.
REQ-029 flush SHALL NOT abort PAIR_LO or the following hi write; a started pair always completes.
REQ-030 wr_en SHALL be 0 in every cycle not listed in REQ-019, REQ-023 and REQ-024; wr_addr and wr_data are don't-care when wr_en=0.
REQ-031 Beats with in_valid=0 SHALL never change state, flags or retired.

Reset
REQ-032 Asserting reset SHALL immediately set state=IDLE, wr_en=0, wr_addr=0, wr_data=0, all flags=0 and retired=0, and clear lo, hi, base and setf.
REQ-033 in_ready SHALL be 0 while reset is asserted and 1 on the first cycle after deassertion.
REQ-034 Reset asserted mid-pair, in WAIT_HI or PAIR_LO, SHALL cancel any write not yet issued.

Verification
REQ-035 Normal beat: rd=3, alu_y=8'h00, alu_c=1, alu_v=0, alu_n=0, setf=1 -> next cycle wr_en=1, wr_addr=3, wr_data=00; C=1, Z=1, V=0, N=0; retired=1.
REQ-036 Wide pair: beat 1 has rd=7, alu_y=8'h34, wide_lo=1, setf=1; beat 2 has alu_y=8'h92 -> writes (7,34) then (0,92) on consecutive cycles; in_ready=0 on the first of these; flags C=1, N=1, Z=0, V=0; retired increments by 1.
REQ-037 Back-to-back: normal beats on 4 consecutive cycles, each with setf=0 -> 4 consecutive writes in order; flags unchanged; retired=4.
REQ-038 Flush in WAIT_HI: send a low beat, then assert flush for one cycle -> no write, flags unchanged, state IDLE; the next normal beat writes normally.
REQ-039 Reset in PAIR_LO: assert reset asynchronously in the PAIR_LO cycle -> wr_en drops immediately, no hi write occurs, flags=0 and retired=0.
REQ-040 Counter wrap: preload retired to 16'hFFFF, then retire one normal beat -> retired=16'h0000.
